// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared Wishbone data-memory types and widths
package wb_pkg;

  localparam int WB_ADR_W  = 32;
  localparam int WB_DAT_W  = 32;
  localparam int WB_SEL_W  = 4;
  localparam int WB_WCNT_W = 4;

  // Responder sequencing: accept in IDLE, count wait states, then complete.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_dmem_slave_if.sv
// rtl/wb_dmem_slave_if.sv - pipelined Wishbone data bus bundle
interface wb_dmem_slave_if;
  import wb_pkg::*;

  logic                wb_cyc_i;
  logic                wb_stb_i;
  logic                wb_we_i;
  logic [WB_ADR_W-1:0] wb_adr_i;
  logic [WB_DAT_W-1:0] wb_dat_i;
  logic [WB_SEL_W-1:0] wb_sel_i;
  logic                wb_stall_o;
  logic                wb_ack_o;
  logic                wb_err_o;
  logic [WB_DAT_W-1:0] wb_dat_o;

  modport master (
    output wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    input  wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

  modport slave (
    input  wb_cyc_i, wb_stb_i, wb_we_i, wb_adr_i, wb_dat_i, wb_sel_i,
    output wb_stall_o, wb_ack_o, wb_err_o, wb_dat_o
  );

endinterface

// File: rtl/dmem_bytelane_ram.sv
// rtl/dmem_bytelane_ram.sv - single-port byte-writable RAM, registered read
module dmem_bytelane_ram
  import wb_pkg::*;
#(
  parameter int DEPTH_WORDS = 4096,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic [AW-1:0]       addr_i,
  input  logic                we_i,
  input  logic [WB_SEL_W-1:0] be_i,
  input  logic [WB_DAT_W-1:0] wdata_i,
  input  logic                re_i,
  output logic [WB_DAT_W-1:0] rdata_o
);

  logic [WB_DAT_W-1:0] mem [DEPTH_WORDS];
  logic [WB_DAT_W-1:0] rdata_q, rdata_d;

  // Array contents are never reset so data survives a bus reset.
  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < WB_SEL_W; i++) begin
        if (be_i[i]) mem[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  // Read register loads only on a read, otherwise returns to zero.
  always_comb begin
    rdata_d = '0;
    if (re_i) rdata_d = mem[addr_i];
  end

  // Read data register doubles as the bus data output register.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rdata_q <= '0;
    else       rdata_q <= rdata_d;
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_dmem_slave.sv
// rtl/wb_dmem_slave.sv - Wishbone B4 pipelined RAM responder; WB_DMEM_ERR_EN enables range errors
module wb_dmem_slave
  import wb_pkg::*;
#(
  parameter logic [WB_ADR_W-1:0] BASE_ADDR   = 32'h0000_0000,
  parameter int                  DEPTH_WORDS = 4096,
  parameter int                  WAIT_STATES = 1
) (
  input  logic             data_wb_clk_i,
  input  logic             data_wb_rst_i,
  wb_dmem_slave_if.slave   wb
);

  localparam int                   AW      = $clog2(DEPTH_WORDS);
  localparam logic [WB_WCNT_W-1:0] WAIT_LD = WB_WCNT_W'(WAIT_STATES);

  wb_state_e           state_q, state_d;
  logic [WB_WCNT_W-1:0] cnt_q, cnt_d;
  logic                we_q, we_d;
  logic [WB_DAT_W-1:0] dat_q, dat_d;
  logic [WB_SEL_W-1:0] sel_q, sel_d;
  logic [AW-1:0]       idx_q, idx_d;
  logic                oor_q, oor_d;
  logic                ack_q, ack_d;
  logic                err_q, err_d;

  logic [WB_ADR_W-1:0] bus_off;
  logic [AW-1:0]       bus_idx;
  logic                bus_oor;
  logic                accept;
  logic                req_oor;
  logic                req_we;
  logic                enter_resp;
  logic                ram_we;
  logic                ram_re;
  logic [AW-1:0]       ram_addr;
  logic [WB_DAT_W-1:0] ram_rdata;
  logic                unused_bits;

  assign bus_off = wb.wb_adr_i - BASE_ADDR;
  assign bus_idx = bus_off[AW+1:2];

`ifdef WB_DMEM_ERR_EN
  // Offset is unsigned, so addresses below the base also wrap out of range.
  assign bus_oor     = (bus_off >= WB_ADR_W'(4 * DEPTH_WORDS));
  assign wb.wb_err_o = err_q;
  assign unused_bits = ^bus_off[1:0];
`else
  assign bus_oor     = 1'b0;
  assign wb.wb_err_o = 1'b0;
  assign unused_bits = ^{bus_off[WB_ADR_W-1:AW+2], bus_off[1:0], err_q};
`endif

  assign accept = (state_q == IDLE) && wb.wb_cyc_i && wb.wb_stb_i;

  // With zero wait states the response is decided on the accepting edge, so
  // the live bus request is used instead of the latched copy.
  assign req_oor = accept ? bus_oor     : oor_q;
  assign req_we  = accept ? wb.wb_we_i  : we_q;

  // Sequencing, request capture and response generation.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    we_d       = we_q;
    dat_d      = dat_q;
    sel_d      = sel_q;
    idx_d      = idx_q;
    oor_d      = oor_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    enter_resp = 1'b0;
    ram_we     = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          we_d  = wb.wb_we_i;
          dat_d = wb.wb_dat_i;
          sel_d = wb.wb_sel_i;
          idx_d = bus_idx;
          oor_d = bus_oor;
          cnt_d = WAIT_LD;
          if (WAIT_STATES != 0) begin
            state_d = WAIT;
          end else begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      WAIT: begin
        if (!wb.wb_cyc_i) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - WB_WCNT_W'(1);
          if (cnt_q <= WB_WCNT_W'(1)) begin
            state_d    = RESP;
            enter_resp = 1'b1;
          end
        end
      end
      RESP: begin
        state_d = IDLE;
        ram_we  = we_q && !oor_q && wb.wb_cyc_i && wb.wb_stb_i;
      end
      default: state_d = IDLE;
    endcase
    if (enter_resp) begin
      ack_d = !req_oor;
      err_d = req_oor;
    end
  end

  assign ram_re   = enter_resp && !req_oor && !req_we;
  assign ram_addr = (state_q == IDLE) ? bus_idx : idx_q;

  // State and registered outputs; reset abandons any pending write.
  always_ff @(posedge data_wb_clk_i or posedge data_wb_rst_i) begin
    if (data_wb_rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      dat_q   <= '0;
      sel_q   <= '0;
      idx_q   <= '0;
      oor_q   <= 1'b0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      dat_q   <= dat_d;
      sel_q   <= sel_d;
      idx_q   <= idx_d;
      oor_q   <= oor_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
    end
  end

  dmem_bytelane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk_i   (data_wb_clk_i),
    .rst_i   (data_wb_rst_i),
    .addr_i  (ram_addr),
    .we_i    (ram_we),
    .be_i    (sel_q),
    .wdata_i (dat_q),
    .re_i    (ram_re),
    .rdata_o (ram_rdata)
  );

  assign wb.wb_stall_o = (state_q != IDLE);
  assign wb.wb_ack_o   = ack_q;
  assign wb.wb_dat_o   = ram_rdata;

endmodule

// File: tb/tb_wb_dmem_slave.sv
// tb/tb_wb_dmem_slave.sv - directed checks for wb_dmem_slave
module tb_wb_dmem_slave;

  localparam logic [31:0] BASE1 = 32'h2000_0000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        dsel = 1'b0;
  logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = '0, dat = '0;
  logic [3:0]  sel = '0;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  wb_dmem_slave_if if1 ();
  wb_dmem_slave_if if3 ();

  assign if1.wb_cyc_i = cyc & ~dsel;
  assign if1.wb_stb_i = stb & ~dsel;
  assign if3.wb_cyc_i = cyc & dsel;
  assign if3.wb_stb_i = stb & dsel;
  assign if1.wb_we_i  = we;
  assign if3.wb_we_i  = we;
  assign if1.wb_adr_i = adr;
  assign if3.wb_adr_i = adr;
  assign if1.wb_dat_i = dat;
  assign if3.wb_dat_i = dat;
  assign if1.wb_sel_i = sel;
  assign if3.wb_sel_i = sel;

  wire        m_stall = dsel ? if3.wb_stall_o : if1.wb_stall_o;
  wire        m_ack   = dsel ? if3.wb_ack_o   : if1.wb_ack_o;
  wire        m_err   = dsel ? if3.wb_err_o   : if1.wb_err_o;
  wire [31:0] m_dat   = dsel ? if3.wb_dat_o   : if1.wb_dat_o;

  wb_dmem_slave #(.BASE_ADDR(BASE1), .DEPTH_WORDS(4096), .WAIT_STATES(1)) dut1 (
    .data_wb_clk_i (clk),
    .data_wb_rst_i (rst),
    .wb            (if1.slave)
  );

  wb_dmem_slave #(.BASE_ADDR(32'h0), .DEPTH_WORDS(256), .WAIT_STATES(3)) dut3 (
    .data_wb_clk_i (clk),
    .data_wb_rst_i (rst),
    .wb            (if3.slave)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // One full transaction; cyc/stb stay high through the response cycle edge.
  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] rd, output logic ak, output logic er,
                      output int lat, output int stl);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dat = d; sel = s;
    @(posedge clk);
    lat = 0; stl = 0; ak = 1'b0; er = 1'b0; rd = '0;
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (m_stall) stl++;
      if (m_ack || m_err) begin
        lat = k; ak = m_ack; er = m_err; rd = m_dat;
        break;
      end
    end
    @(posedge clk);
    #1;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
  endtask

  logic [31:0] rd;
  logic        ak, er, seen;
  int          lat, stl;

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_stall", {31'b0, m_stall}, 32'h0);
    chk("reset_ack",   {31'b0, m_ack},   32'h0);
    chk("reset_err",   {31'b0, m_err},   32'h0);
    chk("reset_dat",   m_dat,            32'h0);
    rst = 1'b0;

    // Basic write then read, one wait state.
    xfer(1'b1, BASE1 + 32'h10, 32'hDEADBEEF, 4'hF, rd, ak, er, lat, stl);
    chk("t1_wr_ack", {31'b0, ak}, 32'h1);
    chk("t1_wr_lat", lat, 2);
    chk("t1_wr_stall", stl, 2);
    xfer(1'b0, BASE1 + 32'h10, 32'h0, 4'h1, rd, ak, er, lat, stl);
    chk("t1_rd_data", rd, 32'hDEADBEEF);
    chk("t1_rd_lat", lat, 2);
    @(negedge clk);
    chk("t1_idle_stall", {31'b0, m_stall}, 32'h0);
    chk("t1_idle_dat", m_dat, 32'h0);

    // Partial lane write and an all-lanes-disabled write.
    xfer(1'b1, BASE1 + 32'h20, 32'h11223344, 4'hF, rd, ak, er, lat, stl);
    xfer(1'b1, BASE1 + 32'h20, 32'hAABBCCDD, 4'b0101, rd, ak, er, lat, stl);
    xfer(1'b0, BASE1 + 32'h20, 32'h0, 4'h0, rd, ak, er, lat, stl);
    chk("t2_lane_merge", rd, 32'h11BB33DD);
    xfer(1'b1, BASE1 + 32'h20, 32'hFFFFFFFF, 4'h0, rd, ak, er, lat, stl);
    chk("t2_sel0_ack", {31'b0, ak}, 32'h1);
    xfer(1'b0, BASE1 + 32'h20, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t2_sel0_keep", rd, 32'h11BB33DD);

    // Three wait states on the second instance.
    dsel = 1'b1;
    xfer(1'b1, 32'h40, 32'h12345678, 4'hF, rd, ak, er, lat, stl);
    xfer(1'b0, 32'h40, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t3_rd_lat", lat, 4);
    chk("t3_rd_stall", stl, 4);
    chk("t3_rd_data", rd, 32'h12345678);
    dsel = 1'b0;

    // One past the top of the window.
    xfer(1'b1, BASE1, 32'h0BADF00D, 4'hF, rd, ak, er, lat, stl);
    xfer(1'b1, BASE1 + 32'h4000, 32'h55667788, 4'hF, rd, ak, er, lat, stl);
`ifdef WB_DMEM_ERR_EN
    chk("t4_oor_err", {31'b0, er}, 32'h1);
    chk("t4_oor_ack", {31'b0, ak}, 32'h0);
    xfer(1'b0, BASE1 + 32'h4000, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t4_oor_rd_dat", rd, 32'h0);
    xfer(1'b0, BASE1, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t4_word0", rd, 32'h0BADF00D);
`else
    chk("t4_wrap_ack", {31'b0, ak}, 32'h1);
    chk("t4_wrap_err", {31'b0, er}, 32'h0);
    xfer(1'b0, BASE1, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t4_word0", rd, 32'h55667788);
`endif

    // Strobe without cycle is ignored.
    seen = 1'b0;
    @(negedge clk);
    stb = 1'b1; we = 1'b1; adr = BASE1 + 32'h10; dat = 32'h0; sel = 4'hF;
    repeat (3) begin
      @(negedge clk);
      if (m_stall || m_ack || m_err) seen = 1'b1;
    end
    stb = 1'b0; we = 1'b0;
    chk("stb_no_cyc", {31'b0, seen}, 32'h0);

    // Abort during the wait state.
    xfer(1'b1, BASE1 + 32'h30, 32'hCAFEBABE, 4'hF, rd, ak, er, lat, stl);
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE1 + 32'h30; dat = 32'h0; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    seen = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (m_ack || m_err) seen = 1'b1;
    end
    chk("t5_abort_resp", {31'b0, seen}, 32'h0);
    xfer(1'b0, BASE1 + 32'h30, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t5_abort_mem", rd, 32'hCAFEBABE);
    chk("t5_next_lat", lat, 2);

    // Abort in the response cycle suppresses the write.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE1 + 32'h30; dat = 32'h0; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("t5b_resp_ack", {31'b0, m_ack}, 32'h1);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    xfer(1'b0, BASE1 + 32'h30, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t5b_resp_mem", rd, 32'hCAFEBABE);

    // Reset during the wait state of a write.
    @(negedge clk);
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = BASE1 + 32'h30; dat = 32'h99999999; sel = 4'hF;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("t6_rst_stall", {31'b0, m_stall}, 32'h0);
    chk("t6_rst_ack",   {31'b0, m_ack},   32'h0);
    chk("t6_rst_dat",   m_dat,            32'h0);
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    xfer(1'b0, BASE1 + 32'h30, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t6_target_kept", rd, 32'hCAFEBABE);
    xfer(1'b0, BASE1 + 32'h10, 32'h0, 4'hF, rd, ak, er, lat, stl);
    chk("t6_prior_kept", rd, 32'hDEADBEEF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
